// File: rtl/uart_rx_axis_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, the
// oversample factor and bit-timing helpers, common with the transmitter.
package uart_rx_axis_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE = 8;
  localparam int CNT_W      = 19;

  // A prescale of zero would stall the timers, so it behaves as one.
  function automatic logic [15:0] eff_prescale(input logic [15:0] p);
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

  function automatic logic [CNT_W-1:0] half_cycles(input logic [15:0] p);
    return CNT_W'(p) * CNT_W'(OVERSAMPLE / 2);
  endfunction

  function automatic logic [CNT_W-1:0] bit_cycles(input logic [15:0] p);
    return CNT_W'(p) * CNT_W'(OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. The reset value
// is a parameter so an idle-high line comes out of reset looking idle.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: plain shift through the two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages, forced to the idle level while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver with AXI-stream output and a single-entry output buffer.
// Optional parity bit is enabled by defining UART_RX_PARITY_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | line idle, waiting for a low level on rxd_s
// ST_START  | half a bit into the start bit; high there means a glitch
// ST_DATA   | sampling DATA_WIDTH bits at bit spacing, LSB first
// ST_PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// ST_STOP   | sampling the stop bit; on a low stop bit, wait for line high
import uart_rx_axis_pkg::*;

module uart_rx_axis #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic [15:0]           prescale,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  output logic                  parity_error
);

  logic rxd_s;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [15:0]           presc_q, presc_d;
  logic                  tvalid_q, tvalid_d;
  logic                  busy_q, busy_d;
  logic                  brk_q, brk_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_q, frame_d;
  logic                  commit;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit_q, par_bit_d;
  logic                  parity_q, parity_d;
`endif

  // Frame FSM, bit timer, shift register and output buffer next-state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    presc_d   = presc_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    busy_d    = busy_q;
    brk_d     = brk_q;
    overrun_d = 1'b0;
    frame_d   = 1'b0;
    commit    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    parity_d  = 1'b0;
`endif

    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxd_s) begin
          presc_d = eff_prescale(prescale);
          cnt_d   = half_cycles(presc_d) - CNT_W'(1);
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (rxd_s) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d     = bit_cycles(presc_q) - CNT_W'(1);
            bit_idx_d = '0;
            state_d   = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d   = {rxd_s, shift_q[DATA_WIDTH-1:1]};
          cnt_d     = bit_cycles(presc_q) - CNT_W'(1);
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == '0) begin
          par_bit_d = rxd_s;
          cnt_d     = bit_cycles(presc_q) - CNT_W'(1);
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        // A low stop bit may be a held break; stay here until the line
        // recovers so the break cannot look like a new start bit.
        if (brk_q) begin
          if (rxd_s) begin
            brk_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == '0) begin
          busy_d = 1'b0;
          if (!rxd_s) begin
            frame_d = 1'b1;
            brk_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_bit_q}) parity_d = 1'b1;
            else                       commit   = 1'b1;
`else
            commit = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        brk_d   = 1'b0;
      end
    endcase

    // A byte landing on an unaccepted one replaces it and flags overrun;
    // a handshake in the same cycle frees the slot, so no overrun then.
    if (commit) begin
      tdata_d   = shift_q;
      tvalid_d  = 1'b1;
      overrun_d = tvalid_q && !m_axis_tready;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      presc_q   <= 16'd1;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      brk_q     <= 1'b0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      presc_q   <= presc_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      busy_q    <= busy_d;
      brk_q     <= brk_d;
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      parity_q  <= parity_d;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign overrun_error = overrun_q;
  assign frame_error   = frame_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = parity_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_axis.sv
// Testbench for uart_rx_axis: bit-bangs UART frames onto rxd and compares
// the AXI-stream output with a queue of bytes the bench itself sent.
module tb_uart_rx_axis;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic [15:0]   prescale = 16'd1;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          busy, overrun_error, frame_error, parity_error;

  uart_rx_axis #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .prescale      (prescale),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .overrun_error (overrun_error),
    .frame_error   (frame_error),
    .parity_error  (parity_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Downstream ready: either random per cycle or a level forced by the test.
  logic rand_ready  = 1'b0;
  logic ready_force = 1'b1;
  always @(posedge clk) begin
    #2;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Monitor: collects accepted beats, counts pulses and checks buffer hold.
  logic [DW-1:0] got_q[$];
  int frame_cnt = 0, overrun_cnt = 0, parity_cnt = 0;
  int valid_cycles = 0, busy_cycles = 0, rise_cyc = 0;
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [DW-1:0] prev_d = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (m_axis_tvalid) valid_cycles++;
      if (busy) busy_cycles++;
      if (frame_error) frame_cnt++;
      if (overrun_error) overrun_cnt++;
      if (parity_error) parity_cnt++;
      if (m_axis_tvalid && !prev_v) rise_cyc = cyc;
      if (prev_v && !prev_r && !overrun_error) begin
        chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
        chk("hold_data", 32'(m_axis_tdata), 32'(prev_d));
      end
      if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
      prev_v = m_axis_tvalid;
      prev_r = m_axis_tready;
      prev_d = m_axis_tdata;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model state: expected bytes and consumption index.
  logic [DW-1:0] exp_q[$];
  int rd = 0;
  int t_start = 0;

  // Called at posedge+1; leaves the caller at posedge+1.
  task automatic hold(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; leaves rxd at the stop-bit level.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input logic par_b);
    int bt;
    bt = (prescale == 16'd0) ? 8 : 8 * int'(prescale);
    t_start = cyc;
    hold(1'b0, bt);
    for (int i = 0; i < DW; i++) hold(d[i], bt);
`ifdef UART_RX_PARITY_EN
    hold(par_b, bt);
`else
    if (par_b === 1'bx) rxd = 1'b1;
`endif
    hold(stop_b, bt);
  endtask

  task automatic check_latency(input string tag);
    int pe, lat, diff;
    pe  = (prescale == 16'd0) ? 1 : int'(prescale);
    lat = 3 + 4 * pe + (DW + 1) * 8 * pe;
`ifdef UART_RX_PARITY_EN
    lat = lat + 8 * pe;
`endif
    diff = rise_cyc - t_start;
    chk(tag, 32'((diff >= lat - 1 && diff <= lat + 1) ? lat : diff), 32'(lat));
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_count"}, 32'(got_q.size() - rd), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (rd + i < got_q.size())
        chk({tag, "_data"}, 32'(got_q[rd + i]), 32'(exp_q[i]));
    rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && (busy || m_axis_tvalid); i++) @(posedge clk);
    #1;
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int f0, o0, p0, v0, b0, n;
    logic [DW-1:0] d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errs", 32'({overrun_error, frame_error, parity_error}), 32'd0);
    rst = 1'b0;
    hold(1'b1, 10);

    // Single 0xA5 at prescale 1.
    f0 = frame_cnt; o0 = overrun_cnt; p0 = parity_cnt; v0 = valid_cycles; b0 = busy_cycles;
    prescale = 16'd1;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    hold(1'b1, 20);
    exp_q.push_back(8'hA5);
    check_beats("a5");
    check_latency("a5_latency");
    chk("a5_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    chk("a5_busy_len", 32'((busy_cycles - b0 >= 70 && busy_cycles - b0 <= 90) ? 1 : 0), 32'd1);
    chk("a5_errs", 32'(frame_cnt - f0 + overrun_cnt - o0 + parity_cnt - p0), 32'd0);

    // 4-cycle low glitch on idle line.
    f0 = frame_cnt; b0 = busy_cycles; v0 = valid_cycles;
    hold(1'b0, 4);
    hold(1'b1, 40);
    chk("glitch_busy_seen", 32'((busy_cycles - b0 > 0) ? 1 : 0), 32'd1);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_valid", 32'(valid_cycles - v0), 32'd0);
    chk("glitch_frame", 32'(frame_cnt - f0), 32'd0);
    check_beats("glitch");

    // Stop bit low followed by a 200-cycle break.
    f0 = frame_cnt; v0 = valid_cycles;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    hold(1'b0, 200);
    chk("brk_no_retrigger", 32'(busy), 32'd0);
    chk("brk_frame_cnt", 32'(frame_cnt - f0), 32'd1);
    chk("brk_valid", 32'(valid_cycles - v0), 32'd0);
    hold(1'b1, 30);
    chk("brk_frame_cnt_after", 32'(frame_cnt - f0), 32'd1);
    check_beats("brk");
    send_frame(8'h5A, 1'b1, ^8'h5A);
    hold(1'b1, 20);
    exp_q.push_back(8'h5A);
    check_beats("brk_recover");

    // Overrun with downstream stalled.
    o0 = overrun_cnt;
    ready_force = 1'b0;
    hold(1'b1, 2);
    send_frame(8'h11, 1'b1, ^8'h11);
    hold(1'b1, 8);
    send_frame(8'h22, 1'b1, ^8'h22);
    hold(1'b1, 20);
    chk("ovr_pulses", 32'(overrun_cnt - o0), 32'd1);
    chk("ovr_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("ovr_tdata", 32'(m_axis_tdata), 32'h22);
    ready_force = 1'b1;
    @(posedge clk); #1;
    ready_force = 1'b0;
    hold(1'b1, 5);
    chk("ovr_drained", 32'(m_axis_tvalid), 32'd0);
    exp_q.push_back(8'h22);
    check_beats("ovr");
    ready_force = 1'b1;
    hold(1'b1, 3);

    // Prescale 2, back-to-back with one bit gap, then reset mid-frame.
    prescale = 16'd2;
    send_frame(8'h00, 1'b1, ^8'h00);
    hold(1'b1, 16);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    hold(1'b1, 40);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    check_beats("p2");
    check_latency("p2_latency");
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 8);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
    rxd = 1'b1;
    hold(1'b1, 5);
    rst = 1'b0;
    hold(1'b1, 300);
    chk("rst_mid_busy_after", 32'(busy), 32'd0);
    check_beats("rst_mid");

`ifdef UART_RX_PARITY_EN
    // Wrong then correct parity bit.
    p0 = parity_cnt; f0 = frame_cnt;
    prescale = 16'd1;
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 20);
    chk("par_bad_pulse", 32'(parity_cnt - p0), 32'd1);
    chk("par_bad_frame", 32'(frame_cnt - f0), 32'd0);
    check_beats("par_bad");
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 20);
    exp_q.push_back(8'h07);
    check_beats("par_good");
    chk("par_good_pulse", 32'(parity_cnt - p0), 32'd1);
`endif

    // Randomized frames, prescale and downstream ready.
    f0 = frame_cnt; o0 = overrun_cnt; p0 = parity_cnt;
    rand_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      prescale = 16'($urandom_range(0, 3));
      d = DW'($urandom);
      for (n = 0; n < 500 && m_axis_tvalid; n++) @(posedge clk);
      #1;
      send_frame(d, 1'b1, ^d);
      exp_q.push_back(d);
      check_latency("rand_latency");
      hold(1'b1, $urandom_range(0, 20));
    end
    wait_idle("rand", 2000);
    rand_ready = 1'b0;
    ready_force = 1'b1;
    hold(1'b1, 5);
    check_beats("rand");
    chk("rand_errs", 32'(frame_cnt - f0 + overrun_cnt - o0 + parity_cnt - p0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
